// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scan-code to ASCII decoder with FWFT key FIFO.
// Optional macro KEYPAD_EN adds numeric keypad translation.
module ps2_key_decoder #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [7:0]  CAPS_CODE  = 8'h58
) (
    input  logic                  clk50,
    input  logic                  reset,
    input  logic                  code_valid,
    input  logic [7:0]            code,
    input  logic                  rd_en,
    output logic                  key_valid,
    output logic [7:0]            key_ascii,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  shift_state,
    output logic                  caps_state,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t                 state;
    logic                   cv_d;
    logic                   strobe;
    logic                   push_r;
    logic [7:0]             ascii_r;
    logic                   hit;
    logic                   letter;
    logic [7:0]             ascii_c;
    logic                   is_shift;

    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic                   full;
    logic                   do_pop;
    logic                   do_push;

    assign strobe   = code_valid & ~cv_d;
    assign is_shift = (code == 8'h12) || (code == 8'h59);

    // Translation uses the shift/caps state from before this strobe's update.
    always_comb begin
        hit     = 1'b1;
        letter  = 1'b0;
        ascii_c = 8'h00;
        case (code)
            8'h1C: begin letter = 1'b1; ascii_c = 8'h61; end
            8'h32: begin letter = 1'b1; ascii_c = 8'h62; end
            8'h21: begin letter = 1'b1; ascii_c = 8'h63; end
            8'h23: begin letter = 1'b1; ascii_c = 8'h64; end
            8'h24: begin letter = 1'b1; ascii_c = 8'h65; end
            8'h2B: begin letter = 1'b1; ascii_c = 8'h66; end
            8'h34: begin letter = 1'b1; ascii_c = 8'h67; end
            8'h33: begin letter = 1'b1; ascii_c = 8'h68; end
            8'h43: begin letter = 1'b1; ascii_c = 8'h69; end
            8'h3B: begin letter = 1'b1; ascii_c = 8'h6A; end
            8'h42: begin letter = 1'b1; ascii_c = 8'h6B; end
            8'h4B: begin letter = 1'b1; ascii_c = 8'h6C; end
            8'h3A: begin letter = 1'b1; ascii_c = 8'h6D; end
            8'h31: begin letter = 1'b1; ascii_c = 8'h6E; end
            8'h44: begin letter = 1'b1; ascii_c = 8'h6F; end
            8'h4D: begin letter = 1'b1; ascii_c = 8'h70; end
            8'h15: begin letter = 1'b1; ascii_c = 8'h71; end
            8'h2D: begin letter = 1'b1; ascii_c = 8'h72; end
            8'h1B: begin letter = 1'b1; ascii_c = 8'h73; end
            8'h2C: begin letter = 1'b1; ascii_c = 8'h74; end
            8'h3C: begin letter = 1'b1; ascii_c = 8'h75; end
            8'h2A: begin letter = 1'b1; ascii_c = 8'h76; end
            8'h1D: begin letter = 1'b1; ascii_c = 8'h77; end
            8'h22: begin letter = 1'b1; ascii_c = 8'h78; end
            8'h35: begin letter = 1'b1; ascii_c = 8'h79; end
            8'h1A: begin letter = 1'b1; ascii_c = 8'h7A; end
            8'h16: ascii_c = shift_state ? 8'h21 : 8'h31;
            8'h1E: ascii_c = shift_state ? 8'h40 : 8'h32;
            8'h26: ascii_c = shift_state ? 8'h23 : 8'h33;
            8'h25: ascii_c = shift_state ? 8'h24 : 8'h34;
            8'h2E: ascii_c = shift_state ? 8'h25 : 8'h35;
            8'h36: ascii_c = shift_state ? 8'h5E : 8'h36;
            8'h3D: ascii_c = shift_state ? 8'h26 : 8'h37;
            8'h3E: ascii_c = shift_state ? 8'h2A : 8'h38;
            8'h46: ascii_c = shift_state ? 8'h28 : 8'h39;
            8'h45: ascii_c = shift_state ? 8'h29 : 8'h30;
            8'h29: ascii_c = 8'h20;
            8'h5A: ascii_c = 8'h0D;
            8'h66: ascii_c = 8'h08;
            8'h0D: ascii_c = 8'h09;
            8'h76: ascii_c = 8'h1B;
`ifdef KEYPAD_EN
            8'h70: ascii_c = 8'h30;
            8'h69: ascii_c = 8'h31;
            8'h72: ascii_c = 8'h32;
            8'h7A: ascii_c = 8'h33;
            8'h6B: ascii_c = 8'h34;
            8'h73: ascii_c = 8'h35;
            8'h74: ascii_c = 8'h36;
            8'h6C: ascii_c = 8'h37;
            8'h75: ascii_c = 8'h38;
            8'h7D: ascii_c = 8'h39;
            8'h79: ascii_c = 8'h2B;
            8'h7B: ascii_c = 8'h2D;
            8'h7C: ascii_c = 8'h2A;
`endif
            default: hit = 1'b0;
        endcase
        if (letter && (shift_state ^ caps_state)) begin
            ascii_c = ascii_c - 8'h20;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            cv_d        <= 1'b0;
            state       <= IDLE;
            shift_state <= 1'b0;
            caps_state  <= 1'b0;
            push_r      <= 1'b0;
            ascii_r     <= 8'h00;
        end else begin
            cv_d   <= code_valid;
            push_r <= 1'b0;
            if (strobe) begin
                case (state)
                    IDLE: begin
                        if (code == 8'hF0) begin
                            state <= BRK;
                        end else if (code == 8'hE0) begin
                            state <= EXT;
                        end else begin
                            if (is_shift) shift_state <= 1'b1;
                            if (code == CAPS_CODE) caps_state <= ~caps_state;
                            if (hit) begin
                                push_r  <= 1'b1;
                                ascii_r <= ascii_c;
                            end
                        end
                    end
                    BRK: begin
                        if (is_shift) shift_state <= 1'b0;
                        state <= IDLE;
                    end
                    EXT:     state <= (code == 8'hF0) ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = rd_en & (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_r & (~full | do_pop);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (push_r && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (do_push) mem[wr_ptr] <= ascii_r;
    end

    assign key_valid  = (count != '0);
    assign key_ascii  = key_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       rd_en = 1'b0;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic [3:0] fifo_count;
    logic       shift_state;
    logic       caps_state;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    ps2_key_decoder dut (
        .clk50       (clk50),
        .reset       (reset),
        .code_valid  (code_valid),
        .code        (code),
        .rd_en       (rd_en),
        .key_valid   (key_valid),
        .key_ascii   (key_ascii),
        .fifo_count  (fifo_count),
        .shift_state (shift_state),
        .caps_state  (caps_state),
        .overflow    (overflow)
    );

    always #10 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk50);
        code = c;
        code_valid = 1'b1;
        repeat (3) @(negedge clk50);
        code_valid = 1'b0;
        repeat (2) @(negedge clk50);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, key_valid, 1'b1);
        check({tag, "_ascii"}, key_ascii, exp);
        @(negedge clk50);
        rd_en = 1'b1;
        @(negedge clk50);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_kv"},    key_valid, 1'b0);
        check({tag, "_ascii"}, key_ascii, 8'h00);
        check({tag, "_cnt"},   fifo_count, 4'd0);
        check({tag, "_shift"}, shift_state, 1'b0);
        check({tag, "_caps"},  caps_state, 1'b0);
        check({tag, "_ovf"},   overflow, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        check_reset_values("rst0");

        // Latency: strobe at edge k, key_valid after edge k+1; code_valid held long.
        @(negedge clk50);
        code = 8'h1C;
        code_valid = 1'b1;
        @(posedge clk50); #1;
        check("lat_k", key_valid, 1'b0);
        @(posedge clk50); #1;
        check("lat_k1", key_valid, 1'b1);
        check("lat_ascii", key_ascii, 8'h61);
        repeat (6) @(negedge clk50);
        code_valid = 1'b0;
        repeat (2) @(negedge clk50);
        check("one_strobe_cnt", fifo_count, 4'd1);
        pop_check("a0", 8'h61);
        check("pop_kv", key_valid, 1'b0);
        check("pop_ascii", key_ascii, 8'h00);

        // Shift and breaks
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        check("sh_cnt", fifo_count, 4'd2);
        check("sh_state", shift_state, 1'b0);
        pop_check("sh_A", 8'h41);
        pop_check("sh_a", 8'h61);

        // Caps lock
        send(8'h58); send(8'h1C); send(8'h16); send(8'h12); send(8'h16);
        check("caps_state", caps_state, 1'b1);
        check("caps_shift", shift_state, 1'b1);
        send(8'h1C);
        pop_check("caps_A", 8'h41);
        pop_check("caps_1", 8'h31);
        pop_check("caps_bang", 8'h21);
        pop_check("caps_shift_a", 8'h61);
        send(8'hF0); send(8'h12); send(8'h58);
        check("caps_off", caps_state, 1'b0);

        // Shifted digits and controls
        send(8'h12); send(8'h1E); send(8'h45); send(8'h29); send(8'h0D);
        send(8'hF0); send(8'h12); send(8'h76); send(8'h66); send(8'h5A);
        pop_check("d_at", 8'h40);
        pop_check("d_rpar", 8'h29);
        pop_check("c_sp", 8'h20);
        pop_check("c_tab", 8'h09);
        pop_check("c_esc", 8'h1B);
        pop_check("c_bs", 8'h08);
        pop_check("c_cr", 8'h0D);

        // Extended and ignored codes
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h32); send(8'hAA); send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'h5A);
        check("ext_kv", key_valid, 1'b0);
        check("ext_cnt", fifo_count, 4'd0);
        send(8'h32);
        pop_check("ext_idle_b", 8'h62);

        // Keypad
        send(8'h12); send(8'h69); send(8'hF0); send(8'h12);
`ifdef KEYPAD_EN
        pop_check("kp_1", 8'h31);
`else
        check("kp_none", fifo_count, 4'd0);
`endif

        // Full, simultaneous push/pop at full, then overflow
        for (int i = 0; i < 8; i++) send(8'h1C);
        check("full_cnt", fifo_count, 4'd8);
        check("full_ovf", overflow, 1'b0);
        @(negedge clk50);
        code = 8'h32;
        code_valid = 1'b1;
        @(negedge clk50);
        rd_en = 1'b1;
        @(negedge clk50);
        rd_en = 1'b0;
        code_valid = 1'b0;
        repeat (2) @(negedge clk50);
        check("pp_cnt", fifo_count, 4'd8);
        check("pp_ovf", overflow, 1'b0);
        send(8'h1C);
        check("ovf_cnt", fifo_count, 4'd8);
        check("ovf_set", overflow, 1'b1);
        for (int i = 0; i < 7; i++) pop_check("wrap_a", 8'h61);
        pop_check("wrap_b", 8'h62);
        check("drain_cnt", fifo_count, 4'd0);
        check("ovf_sticky", overflow, 1'b1);

        // Reset clears state, including a pending break prefix
        send(8'h58); send(8'h12); send(8'h1C); send(8'hF0);
        do_reset();
        check_reset_values("rst1");
        send(8'h1C);
        pop_check("rst_prefix", 8'h61);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 receiver (ReadPS2) and consumes its value/received outputs.
- Interprets Set-2 scan-code sequences: make, break (F0), extended (E0), Shift and Caps Lock.
- Translates key presses to ASCII and buffers them in a small first-word-fall-through FIFO for a CPU or display consumer, using a valid/read handshake.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).
- CAPS_CODE, 8'h58, scan code of the Caps Lock key.

Ports:
- clk50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- code_valid  input  1  receiver "received" level; each rising edge marks one new code.
- code  input  8  receiver scan code; must be stable while code_valid is high.
- rd_en  input  1  pop request; ignored when key_valid=0.
- key_valid  output  1  FIFO not empty.
- key_ascii  output  8  head-of-FIFO ASCII; 8'h00 when empty.
- fifo_count  output  DEPTH_LOG2+1  current number of entries.
- shift_state  output  1  Left or Right Shift currently held.
- caps_state  output  1  Caps Lock toggle state.
- overflow  output  1  sticky flag: a key was dropped because the FIFO was full.

Behaviour:
- Reset is asynchronous; clk50 is the only clock.
  - Reset values: key_valid=0, key_ascii=8'h00, fifo_count=0, shift_state=0, caps_state=0, overflow=0, FSM=IDLE, FIFO pointers=0.
  - Reset mid-sequence discards any partial F0/E0 prefix.
- Strobe: cv_d is a registered copy of code_valid; strobe = code_valid & ~cv_d. code_valid held high for many clk50 cycles yields exactly one strobe.
- FSM transitions (evaluated only on strobe):
  - IDLE: F0→BRK; E0→EXT; else process as make, stay IDLE.
  - BRK: process as break→IDLE.
  - EXT: F0→EXT_BRK; else ignore code→IDLE.
  - EXT_BRK: ignore code→IDLE.
- Make processing:
  - 12/59 set shift_state=1.
  - CAPS_CODE toggles caps_state.
  - A code in the table pushes its ASCII.
  - Any other code is ignored.
- Break processing:
  - 12/59 clear shift_state.
  - All other codes are ignored, with no push.
- Codes AA, FA, EE, FE, 00, FF received in IDLE are ignored and the FSM stays IDLE.
- Table, unshifted/shifted:
  - Letters: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A. Uppercase when shift_state XOR caps_state, else lowercase.
  - Digits: 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46 0=45. With Shift (caps has no effect): ! @ # $ % ^ & * ( ).
  - Controls: 29→20, 5A→0D, 66→08, 0D→09, 76→1B. These ignore shift and caps.
- Shift/caps value used for translation is the value before the current strobe's update.
- Latency: strobe at edge k registers the translated byte and a push flag. The FIFO write occurs at edge k+1, so key_valid is high after edge k+1.
- FIFO:
  - Pop occurs on the edge where rd_en & key_valid; key_ascii shows the next entry after that edge.
  - Push with count=2^DEPTH_LOG2 and no pop: byte dropped, overflow←1. overflow is cleared only by reset.
  - Simultaneous push and pop: both occur and the count is unchanged. This holds when full too: no drop, no overflow.
  - Pointers wrap modulo 2^DEPTH_LOG2.

Optional Feature:
- Macro: KEYPAD_EN.
- Defined: keypad make codes translate to digits regardless of shift/caps: 70=0 69=1 72=2 7A=3 6B=4 73=5 74=6 6C=7 75=8 7D=9 79=+ 7B=- 7C=*. Note: E0 4A (keypad /) and E0 5A (keypad Enter) remain ignored.
- Undefined: these codes are ignored like any unlisted code.

Test Plan:
- Reset, then strobe 1C → key_ascii=8'h61, key_valid=1 two cycles after the strobe; rd_en pulse → key_valid=0, key_ascii=00.
- Strobe 12, 1C, F0 1C, F0 12, 1C → FIFO holds 41 then 61; shift_state ends 0.
- Strobe 58, 1C, 16, 12 16 → FIFO 41, 31, 21; caps_state=1.
- Strobe E0 75, E0 F0 75, F0 32, AA → no push, FSM IDLE, key_valid=0.
- 9 makes of 1C with no reads (DEPTH_LOG2=3) → fifo_count=8, overflow=1; then push with rd_en same cycle → count stays 8, overflow unchanged; reset → all outputs at reset values.
- With KEYPAD_EN, strobe 12 then 69 → 31; without KEYPAD_EN → no push.
